// File: rtl/io_port_6502_if.sv
// Bus bundle for io_port_6502: CPU snoop side plus the outgoing byte stream.
// master = CPU/consumer side, slave = the port itself.
interface io_port_6502_if;
  logic        clk2out;
  logic [15:0] ab;
  logic [7:0]  db_o;
  logic        rw;
  logic        rd_hit;
  logic [7:0]  rd_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        overflow;

  modport master (
    output clk2out, ab, db_o, rw, tx_ready,
    input  rd_hit, rd_data, tx_valid, tx_data, overflow
  );

  modport slave (
    input  clk2out, ab, db_o, rw, tx_ready,
    output rd_hit, rd_data, tx_valid, tx_data, overflow
  );
endinterface

// File: rtl/io_port_6502.sv
// Memory-mapped output port on the 6502 bus: snoops CPU writes into a FIFO
// that drains through a valid/ready byte stream; status readable by the CPU.
module io_port_6502 #(
  parameter logic [15:0] DATA_ADDR   = 16'hF001,
  parameter logic [15:0] STATUS_ADDR = 16'hF002,
  parameter int          AW          = 4
) (
  input logic           eclk,
  input logic           ereset_n,
  io_port_6502_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          r_phi2_q;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [7:0]    r_mem [DEPTH];

  logic          w_phi2_fall;
  logic          w_wr_data;
  logic          w_wr_stat;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_cnt_ext;
  logic [4:0]    w_cnt5;

  assign w_phi2_fall = r_phi2_q & ~bus.clk2out;
  assign w_wr_data   = w_phi2_fall & ~bus.rw
                     & (bus.ab == DATA_ADDR);
  assign w_wr_stat   = w_phi2_fall & ~bus.rw
                     & (bus.ab == STATUS_ADDR);

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & bus.tx_ready;
  // full is judged on the pre-pop count, so a same-cycle pop frees a slot
  assign w_push  = w_wr_data & (~w_full | w_pop);
  assign w_drop  = w_wr_data & ~w_push;

  assign w_cnt_ext = 32'(r_count);
  assign w_cnt5    = (w_cnt_ext > 32'd31) ? 5'd31
                                          : w_cnt_ext[4:0];

  assign bus.rd_hit   = bus.rw & (bus.ab == STATUS_ADDR);
  assign bus.rd_data  = {r_overflow, w_full, w_empty, w_cnt5};
  assign bus.tx_valid = ~w_empty;
  assign bus.tx_data  = r_mem[r_rd_ptr];
  assign bus.overflow = r_overflow;

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      r_phi2_q <= 1'b0;
    end else begin
      r_phi2_q <= bus.clk2out;
    end
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_wr_stat) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge eclk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.db_o;
  end
endmodule

// File: tb/tb_io_port_6502.sv
// Bench for io_port_6502: directed scenarios plus random bus traffic,
// checked against a byte-queue reference of the port.
module tb_io_port_6502;
  localparam logic [15:0] DA = 16'hF001;
  localparam logic [15:0] SA = 16'hF002;
  localparam int DEPTH = 16;

  logic eclk;
  logic ereset_n;
  io_port_6502_if bus();

  io_port_6502 dut (
    .eclk     (eclk),
    .ereset_n (ereset_n),
    .bus      (bus)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [7:0] q[$];
  bit m_ovf;
  bit m_phi2;
  bit rand_rdy;

  task automatic chk8(string tag, logic [7:0] obs,
                      logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    int n;
    n = q.size();
    return {m_ovf, n == DEPTH, n == 0,
            5'((n > 31) ? 31 : n)};
  endfunction

  task automatic m_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_phi2 = 1'b0;
  endtask

  // One eclk cycle: apply the spec's rules to the queue, then compare.
  task automatic tick();
    bit fall, pop, wr, st;
    int sz;
    if (rand_rdy)
      bus.tx_ready = ($urandom_range(0, 9) == 0);
    #1;
    if (!ereset_n) begin
      m_reset();
    end else begin
      sz   = q.size();
      fall = m_phi2 && !bus.clk2out;
      pop  = bus.tx_ready && sz > 0;
      wr   = fall && !bus.rw && bus.ab == DA;
      st   = fall && !bus.rw && bus.ab == SA;
      if (pop) void'(q.pop_front());
      if (st) m_ovf = 1'b0;
      if (wr) begin
        if (sz < DEPTH || pop) q.push_back(bus.db_o);
        else m_ovf = 1'b1;
      end
      m_phi2 = bus.clk2out;
    end
    @(posedge eclk);
    #1;
    chk1("tx_valid", bus.tx_valid, q.size() != 0);
    chk1("overflow", bus.overflow, m_ovf);
    if (q.size() != 0)
      chk8("tx_data", bus.tx_data, q[0]);
  endtask

  task automatic check_rd(logic [15:0] a, logic r);
    bit hit;
    hit = r && a == SA;
    chk1("rd_hit", bus.rd_hit, hit);
    if (hit) chk8("rd_data", bus.rd_data, m_status());
  endtask

  task automatic bus_cycle(logic [15:0] a, logic [7:0] d,
                           logic r, int hold, bit fr);
    bus.ab = a;
    bus.db_o = d;
    bus.rw = r;
    bus.clk2out = 1'b1;
    #1;
    check_rd(a, r);
    repeat (hold) tick();
    bus.clk2out = 1'b0;
    if (fr) bus.tx_ready = 1'b1;
    tick();
    if (fr) bus.tx_ready = 1'b0;
    bus.rw = 1'b1;
    bus.ab = 16'h0000;
  endtask

  task automatic wr(logic [7:0] d);
    bus_cycle(DA, d, 1'b0, 1, 1'b0);
  endtask

  task automatic status_is(string tag, logic [7:0] exp);
    bus.ab = SA;
    bus.rw = 1'b1;
    #1;
    chk1({tag, "_hit"}, bus.rd_hit, 1'b1);
    chk8(tag, bus.rd_data, exp);
    bus.ab = 16'h0000;
  endtask

  initial begin
    int sel;
    logic [15:0] ra;
    logic rr;
    ereset_n = 1'b0;
    rand_rdy = 1'b0;
    bus.clk2out = 1'b0;
    bus.ab = 16'h0000;
    bus.db_o = 8'h00;
    bus.rw = 1'b1;
    bus.tx_ready = 1'b0;
    m_reset();
    repeat (2) tick();
    ereset_n = 1'b1;
    tick();

    chk1("rst_valid", bus.tx_valid, 1'b0);
    chk1("rst_ovf", bus.overflow, 1'b0);
    status_is("rst_status", 8'h20);

    wr(8'h48);
    wr(8'h49);
    tick();
    chk8("two_head", bus.tx_data, 8'h48);
    status_is("two_status", 8'h02);
    bus.tx_ready = 1'b1;
    chk8("two_out0", bus.tx_data, 8'h48);
    tick();
    chk8("two_out1", bus.tx_data, 8'h49);
    tick();
    bus.tx_ready = 1'b0;
    chk1("two_empty", bus.tx_valid, 1'b0);

    for (int i = 0; i < 17; i++) wr(8'(i));
    status_is("full_status", 8'hD0);
    chk1("full_ovf", bus.overflow, 1'b1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk8("drain", bus.tx_data, 8'(i));
      tick();
    end
    bus.tx_ready = 1'b0;
    chk1("drain_empty", bus.tx_valid, 1'b0);
    bus_cycle(SA, 8'h5C, 1'b0, 1, 1'b0);
    status_is("clr_status", 8'h20);

    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    bus_cycle(DA, 8'hAA, 1'b0, 1, 1'b1);
    status_is("pp_status", 8'h50);
    chk1("pp_ovf", bus.overflow, 1'b0);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk8("pp_last", bus.tx_data, 8'hAA);
      tick();
    end
    bus.tx_ready = 1'b0;

    bus_cycle(DA, 8'h77, 1'b0, 10, 1'b0);
    status_is("hold_status", 8'h01);
    bus_cycle(16'hF003, 8'h33, 1'b0, 2, 1'b0);
    status_is("f003_status", 8'h01);
    bus.ab = DA;
    bus.rw = 1'b1;
    #1;
    chk1("rd_f001_hit", bus.rd_hit, 1'b0);
    bus_cycle(DA, 8'h00, 1'b1, 2, 1'b0);
    status_is("rd_f001_status", 8'h01);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;

    for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
    #2;
    ereset_n = 1'b0;
    #1;
    chk1("arst_valid", bus.tx_valid, 1'b0);
    status_is("arst_status", 8'h20);
    bus.tx_ready = 1'b0;
    repeat (2) tick();
    ereset_n = 1'b1;
    tick();
    wr(8'h5A);
    tick();
    chk8("post_rst_first", bus.tx_data, 8'h5A);

    rand_rdy = 1'b1;
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 9);
      ra  = (sel < 7) ? DA : (sel < 8) ? SA : 16'hF003;
      rr  = ($urandom_range(0, 4) == 0);
      bus_cycle(ra, 8'($urandom), rr,
                $urandom_range(1, 3), 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (DEPTH + 2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
